dds_ddc_center_axis_stall_detector: RTL

Produces the per-channel `axis_block_sigs` vector consumed by the dds_ddc_center deadlock monitor. It watches the kernel's AXI-Stream ports and classifies each port as blocked after a configurable run of consecutive stalled cycles. It also reports the first unreported blocked channel to a debug/CSR consumer over a valid/ack handshake. It sits beside the dds_ddc_center kernel instance, between its stream ports and the deadlock monitor.

---
 rtl/dds_ddc_center_deadlock_pkg.sv | 20 ++
 rtl/dds_ddc_center_stall_counter.sv | 52 +++++
 rtl/dds_ddc_center_axis_stall_detector.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dds_ddc_center_deadlock_pkg.sv
// Shared defaults, report FSM state type and index-width helper for the stall detector.
// Latency: none (types and constants only).
// Backpressure: none.
package dds_ddc_center_deadlock_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_THRESH = 1024;

  typedef enum logic {
    RPT_IDLE   = 1'b0,
    RPT_REPORT = 1'b1
  } rpt_state_e;

  // Width of a channel index; never zero so a single-channel build still has a port bit.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dds_ddc_center_stall_counter.sv
// Per-port consecutive-stall counter with a registered "blocked" flag.
// Latency: flag rises on the edge closing the THRESH-th stalled cycle, falls one edge after the first non-stall.
// Backpressure: none; observes a stall qualifier only.
module dds_ddc_center_stall_counter
  import dds_ddc_center_deadlock_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             blocked_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   THRESH_W = (CNT_W+1)'(THRESH);
  localparam logic [CNT_W:0]   ONE_W    = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blk_q, blk_d;
  logic [CNT_W:0]   cnt_inc;

  // Any break in the stall run (or detection disabled) restarts the count from zero.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + ONE_W;
    cnt_d   = '0;
    blk_d   = 1'b0;
    if (enable_i && stall_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_inc[CNT_W-1:0];
      // cnt_inc is one bit wider, so a saturated counter still compares as >= THRESH.
      blk_d = (cnt_inc >= THRESH_W);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      blk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign blocked_o = blk_q;

endmodule

// File: rtl/dds_ddc_center_axis_stall_detector.sv
// Classifies dds_ddc_center AXI-Stream ports as blocked and reports the first unreported one.
// Latency: axis_block_sigs after THRESH stalled cycles; rpt_valid one cycle after a bit rises (FSM idle).
// Backpressure: report held stable until rpt_ack; built only with DDS_DDC_CENTER_BLOCK_REPORT_EN defined.
module dds_ddc_center_axis_stall_detector
  import dds_ddc_center_deadlock_pkg::*;
#(
  parameter int unsigned       NUM_CH   = DEF_NUM_CH,
  parameter int unsigned       CNT_W    = DEF_CNT_W,
  parameter int unsigned       THRESH   = DEF_THRESH,
  parameter logic [NUM_CH-1:0] OUT_MASK = 4'b1100
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             ch_tvalid,
  input  logic [NUM_CH-1:0]             ch_tready,
  output logic [NUM_CH-1:0]             axis_block_sigs,
  output logic                          rpt_valid,
  output logic [ch_idx_w(NUM_CH)-1:0]   rpt_ch,
  output logic [CNT_W-1:0]              rpt_cycles,
  input  logic                          rpt_ack
);

  logic [NUM_CH-1:0]            stall;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;

  // Outputs stall on backpressure (data offered, not taken); inputs stall on starvation.
  assign stall = (OUT_MASK & ch_tvalid & ~ch_tready) | (~OUT_MASK & ch_tready & ~ch_tvalid);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    dds_ddc_center_stall_counter #(
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
    ) u_cnt (
      .clk_i     (clock),
      .rst_i     (reset),
      .enable_i  (enable),
      .stall_i   (stall[gi]),
      .cnt_o     (cnt[gi]),
      .blocked_o (axis_block_sigs[gi])
    );
  end

`ifdef DDS_DDC_CENTER_BLOCK_REPORT_EN
  localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

  rpt_state_e        state_q, state_d;
  logic [NUM_CH-1:0] reported_q, reported_d;
  logic [NUM_CH-1:0] cand, pick_oh;
  logic [IDX_W-1:0]  pick_idx, rpt_ch_q, rpt_ch_d;
  logic [CNT_W-1:0]  pick_cnt, rpt_cycles_q, rpt_cycles_d;
  logic              pick_any;

  // Lowest-index channel that is blocked and not yet reported in its current blocked episode.
  always_comb begin
    cand     = axis_block_sigs & ~reported_q;
    pick_oh  = '0;
    pick_idx = '0;
    pick_cnt = '0;
    pick_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_idx   = IDX_W'(i);
        pick_cnt   = cnt[i];
        pick_any   = 1'b1;
      end
    end
  end

  // Report FSM: capture in IDLE, hold in REPORT until acked; reported bits die with their block flag.
  always_comb begin
    state_d      = state_q;
    rpt_ch_d     = rpt_ch_q;
    rpt_cycles_d = rpt_cycles_q;
    reported_d   = reported_q & axis_block_sigs;
    case (state_q)
      RPT_IDLE: begin
        if (pick_any) begin
          state_d      = RPT_REPORT;
          rpt_ch_d     = pick_idx;
          rpt_cycles_d = pick_cnt;
          reported_d   = (reported_q | pick_oh) & axis_block_sigs;
        end
      end
      RPT_REPORT: begin
        if (rpt_ack) state_d = RPT_IDLE;
      end
      default: state_d = RPT_IDLE;
    endcase
  end

  // Report state and capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RPT_IDLE;
      reported_q   <= '0;
      rpt_ch_q     <= '0;
      rpt_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      reported_q   <= reported_d;
      rpt_ch_q     <= rpt_ch_d;
      rpt_cycles_q <= rpt_cycles_d;
    end
  end

  assign rpt_valid  = (state_q == RPT_REPORT);
  assign rpt_ch     = rpt_ch_q;
  assign rpt_cycles = rpt_cycles_q;
`else
  // Report path not built: outputs parked at zero, ack and counts have no consumer.
  logic unused_rpt;
  assign unused_rpt = rpt_ack ^ (^cnt);
  assign rpt_valid  = 1'b0;
  assign rpt_ch     = '0;
  assign rpt_cycles = '0;
`endif

endmodule
